rx_fifo_stage_full: RTL and testbench
=====================================

# rx_fifo_stage_full

Receive-path counterpart of the transmit FIFO staging buffer: takes decoded words from the rx de-escaper and writes them into the rx FIFO. The de-escaper cannot be stalled, so the block absorbs short FIFO-full periods in a 4-entry circular buffer. When that buffer overflows, the block drops the incoming word, counts it, and flags it. It sits between the de-escaper output and the rx FIFO write port, in the same clock domain.

## Interface
- WR_WIDTH, 12, word width of de-escaper output and FIFO write data
- CNT_WIDTH, 8, width of saturating drop counter
- clock  input  1  block clock, all state on rising edge
- reset_n  input  1  reset, synchronous, active-low
- in_enable  input  1  clock enable; when low no state changes
- in_en  input  1  de-escaper word valid
- in_data  input  WR_WIDTH  de-escaper word
- in_full  input  1  rx FIFO full; no write may be issued while high
- out_en  output  1  FIFO write strobe
- out_data  output  WR_WIDTH  FIFO write data
- level  output  3  buffer occupancy, 0..4
- almost_full  output  1  level >= 3
- overflow  output  1  sticky: at least one word dropped since last clear
- drop_cnt  output  CNT_WIDTH  saturating count of dropped words
- clr_drop  input  1  clears overflow and drop_cnt

## Operation
- Storage: 4 entries of WR_WIDTH bits, 2-bit wr_ptr and rd_ptr (wrap 3->0), 3-bit count.
- Pop condition: pop = in_enable && count!=0 && !in_full.
- out_en = pop. out_data = mem[rd_ptr], driven combinationally from the register array.
- Push request: req = in_enable && in_en.
- Accept condition: accept = req && (count<4 || pop). A full buffer with a simultaneous pop accepts the word.
- Drop condition: drop = req && count==4 && !pop. The word is discarded and no pointer moves.
- On accept: mem[wr_ptr] <= in_data, then wr_ptr++.
- On pop: rd_ptr++.
- Count update: count += accept - pop. An accept and a pop in the same cycle leave count unchanged.
- Drop accounting:
  - On drop: overflow <= 1, and drop_cnt increments, holding at all-ones (saturating).
  - On clr_drop (qualified by in_enable): overflow <= 0 and drop_cnt <= 0.
  - clr_drop and drop in the same cycle: the result is overflow=1 and drop_cnt=1.
- Behaviour while in_enable is low:
  - in_en and clr_drop are ignored.
  - Ignored words are not counted as drops.
  - out_en is 0 and all registers hold.
- No bypass: a word always lands in the buffer first.
- Ordering: words are written to the FIFO in arrival order with no duplication. The only loss is explicit drops.

## Timing
- Reset (reset_n low at a rising edge):
  - wr_ptr, rd_ptr and count go to 0.
  - All mem entries go to 0.
  - overflow goes to 0 and drop_cnt goes to 0.
  - Resulting outputs: out_en=0, out_data=0, level=0, almost_full=0.
- Reset overrides in_enable.
- Reset mid-operation discards buffered words without counting them as drops.
- Latency: a word accepted at edge N can appear with out_en=1 in cycle N+1, if in_full=0 and in_enable=1.
- Sustained throughput: 1 word/cycle with in_full low. level stays at 1 under continuous input.
- Full boundary:
  - count==4, in_full=1, in_en=1: drop.
  - count==4, in_full=0, in_en=1: accept and pop, count stays 4.
- Empty boundary: with count==0, out_en=0 regardless of in_full.
- Status outputs:
  - level, almost_full, overflow and drop_cnt are registered values, updated at the edge following the event.
  - Exception: out_en/out_data are combinational from the current state and in_full.

## Test plan
- Pass-through: reset, then in_full=0 and in_en=1 for 8 cycles with data 0x001..0x008 -> out_en high from cycle 1 to 8, data 0x001..0x008 in order, level=1 throughout, drop_cnt=0.
- Absorb and drain: in_full=1, push 0xA01..0xA04 -> level=4, almost_full=1 after the 3rd push, out_en=0. Then release in_full -> 4 writes 0xA01..0xA04, level back to 0.
- Overflow: in_full=1, push 6 words -> first 4 buffered, words 5 and 6 dropped, overflow=1, drop_cnt=2. Release -> only the first 4 words are written. clr_drop -> overflow=0, drop_cnt=0.
- Full with simultaneous pop: count=4, in_full=0, push 0xB05 -> no drop, count stays 4, 0xB05 emerges 4 cycles later after the older words.
- Saturation and clear race: CNT_WIDTH=8, force 300 drops -> drop_cnt=0xFF. Assert clr_drop together with a drop -> drop_cnt=1, overflow=1.
- Enable gating and reset: in_enable=0 with in_en=1 for 5 cycles -> no state change, no drops counted, out_en=0. Then reset_n low with count=3 -> all outputs 0 the next cycle.

Source files
------------

// File: rtl/rx_fifo_stage_full.sv
// rx_fifo_stage_full: 4-entry staging buffer between rx de-escaper and rx FIFO, dropping and counting words on overflow
module rx_fifo_stage_full #(
  parameter int WR_WIDTH  = 12,
  parameter int CNT_WIDTH = 8
) (
  input  logic                 clock,
  input  logic                 reset_n,
  input  logic                 in_enable,
  input  logic                 in_en,
  input  logic [WR_WIDTH-1:0]  in_data,
  input  logic                 in_full,
  output logic                 out_en,
  output logic [WR_WIDTH-1:0]  out_data,
  output logic [2:0]           level,
  output logic                 almost_full,
  output logic                 overflow,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  input  logic                 clr_drop
);
  logic [WR_WIDTH-1:0] mem [4];
  logic [1:0] wr_ptr, rd_ptr;
  logic [2:0] count;
  logic pop, req, accept, drop, clr;
  assign pop         = in_enable && count != 3'd0 && !in_full;
  assign req         = in_enable && in_en;
  assign accept      = req && (count != 3'd4 || pop);
  assign drop        = req && count == 3'd4 && !pop;
  assign clr         = in_enable && clr_drop;
  assign out_en      = pop;
  assign out_data    = mem[rd_ptr];
  assign level       = count;
  assign almost_full = count >= 3'd3;
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      for (int i = 0; i < 4; i++) mem[i] <= '0;
    end else begin
      if (accept) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + 2'd1;
      end
      if (pop) rd_ptr <= rd_ptr + 2'd1;
      count <= count + 3'(accept) - 3'(pop);
      // a drop racing a clear counts as the first drop after the clear
      if (clr) begin
        overflow <= drop;
        drop_cnt <= drop ? CNT_WIDTH'(1) : '0;
      end else if (drop) begin
        overflow <= 1'b1;
        drop_cnt <= &drop_cnt ? drop_cnt : drop_cnt + CNT_WIDTH'(1);
      end
    end
  end
endmodule

// File: tb/tb_rx_fifo_stage_full.sv
// tb_rx_fifo_stage_full: directed checks of buffering, drop accounting, enable gating and reset
module tb_rx_fifo_stage_full;
  logic        clock = 1'b0;
  logic        reset_n, in_enable, in_en, in_full, clr_drop;
  logic [11:0] in_data;
  logic        out_en, almost_full, overflow;
  logic [11:0] out_data;
  logic [2:0]  level;
  logic [7:0]  drop_cnt;
  int n_cmp = 0, n_err = 0;

  rx_fifo_stage_full #(.WR_WIDTH(12), .CNT_WIDTH(8)) dut (
    .clock(clock), .reset_n(reset_n), .in_enable(in_enable), .in_en(in_en),
    .in_data(in_data), .in_full(in_full), .out_en(out_en), .out_data(out_data),
    .level(level), .almost_full(almost_full), .overflow(overflow),
    .drop_cnt(drop_cnt), .clr_drop(clr_drop)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic ena, input logic en, input logic [11:0] d, input logic full, input logic clr);
    in_enable = ena; in_en = en; in_data = d; in_full = full; clr_drop = clr;
    #1;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    drive(1, 0, 12'h0, 0, 0);
    step(); step();
    reset_n = 1'b1;
    chk("rst_out_en", 32'(out_en), 0);
    chk("rst_out_data", 32'(out_data), 0);
    chk("rst_level", 32'(level), 0);
    chk("rst_almost_full", 32'(almost_full), 0);
    chk("rst_overflow", 32'(overflow), 0);
    chk("rst_drop_cnt", 32'(drop_cnt), 0);

    for (int i = 1; i <= 8; i++) begin
      drive(1, 1, 12'(i), 0, 0);
      chk("pass_out_en", 32'(out_en), (i == 1) ? 0 : 1);
      if (i > 1) chk("pass_out_data", 32'(out_data), 32'(i - 1));
      step();
      chk("pass_level", 32'(level), 1);
    end
    drive(1, 0, 12'h0, 0, 0);
    chk("pass_last_en", 32'(out_en), 1);
    chk("pass_last_data", 32'(out_data), 32'h008);
    step();
    chk("pass_level_end", 32'(level), 0);
    chk("pass_drop_cnt", 32'(drop_cnt), 0);

    for (int k = 1; k <= 4; k++) begin
      drive(1, 1, 12'hA00 + 12'(k), 1, 0);
      chk("absorb_out_en", 32'(out_en), 0);
      step();
      chk("absorb_level", 32'(level), 32'(k));
      chk("absorb_almost_full", 32'(almost_full), (k >= 3) ? 1 : 0);
    end
    drive(1, 0, 12'h0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      chk("drain_out_en", 32'(out_en), 1);
      chk("drain_out_data", 32'(out_data), 32'hA01 + 32'(j));
      step();
      chk("drain_level", 32'(level), 32'(3 - j));
    end
    chk("drain_empty_en", 32'(out_en), 0);

    for (int k = 1; k <= 6; k++) begin
      drive(1, 1, 12'hC00 + 12'(k), 1, 0);
      step();
      chk("ovf_level", 32'(level), (k > 4) ? 4 : 32'(k));
      chk("ovf_drop_cnt", 32'(drop_cnt), (k > 4) ? 32'(k - 4) : 0);
      chk("ovf_flag", 32'(overflow), (k > 4) ? 1 : 0);
    end
    drive(1, 0, 12'h0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      chk("ovf_drain_en", 32'(out_en), 1);
      chk("ovf_drain_data", 32'(out_data), 32'hC01 + 32'(j));
      step();
    end
    chk("ovf_drained_en", 32'(out_en), 0);
    chk("ovf_drained_level", 32'(level), 0);
    drive(1, 0, 12'h0, 0, 1);
    step();
    chk("clr_overflow", 32'(overflow), 0);
    chk("clr_drop_cnt", 32'(drop_cnt), 0);

    for (int k = 1; k <= 4; k++) begin
      drive(1, 1, 12'hB00 + 12'(k), 1, 0);
      step();
    end
    chk("fullpop_level_pre", 32'(level), 4);
    drive(1, 1, 12'hB05, 0, 0);
    chk("fullpop_out_en", 32'(out_en), 1);
    chk("fullpop_out_data", 32'(out_data), 32'hB01);
    step();
    chk("fullpop_level", 32'(level), 4);
    chk("fullpop_drop_cnt", 32'(drop_cnt), 0);
    chk("fullpop_overflow", 32'(overflow), 0);
    drive(1, 0, 12'h0, 0, 0);
    for (int j = 0; j < 4; j++) begin
      chk("fullpop_drain_en", 32'(out_en), 1);
      chk("fullpop_drain_data", 32'(out_data), 32'hB02 + 32'(j));
      step();
    end
    chk("fullpop_level_end", 32'(level), 0);

    for (int i = 0; i < 304; i++) begin
      drive(1, 1, 12'hE00 + 12'(i), 1, 0);
      step();
    end
    chk("sat_drop_cnt", 32'(drop_cnt), 32'hFF);
    chk("sat_overflow", 32'(overflow), 1);
    chk("sat_level", 32'(level), 4);
    drive(1, 1, 12'h777, 1, 1);
    step();
    chk("race_drop_cnt", 32'(drop_cnt), 1);
    chk("race_overflow", 32'(overflow), 1);

    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 12'h555, 0, 1);
      chk("gate_out_en", 32'(out_en), 0);
      step();
    end
    chk("gate_level", 32'(level), 4);
    chk("gate_drop_cnt", 32'(drop_cnt), 1);
    chk("gate_overflow", 32'(overflow), 1);
    drive(1, 0, 12'h0, 0, 0);
    chk("gate_hold_data", 32'(out_data), 32'hE00);
    step();
    chk("prereset_level", 32'(level), 3);
    chk("prereset_af", 32'(almost_full), 1);

    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    #1;
    chk("mid_rst_out_en", 32'(out_en), 0);
    chk("mid_rst_out_data", 32'(out_data), 0);
    chk("mid_rst_level", 32'(level), 0);
    chk("mid_rst_af", 32'(almost_full), 0);
    chk("mid_rst_overflow", 32'(overflow), 0);
    chk("mid_rst_drop_cnt", 32'(drop_cnt), 0);
    drive(1, 1, 12'h123, 0, 0);
    step();
    drive(1, 0, 12'h0, 0, 0);
    chk("post_rst_en", 32'(out_en), 1);
    chk("post_rst_data", 32'(out_data), 32'h123);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
